// File: rtl/decrypt_pkg.sv
// decrypt_pkg: definitions shared by the decryption datapath blocks.
//   D_WIDTH    - character width
//   EOM_CHAR   - end-of-message marker
//   channel_e  - decryptor channel encodings, plus the illegal code
//   in_state_e - message-tracking state of the input dispatcher
package decrypt_pkg;

    localparam int unsigned           D_WIDTH  = 8;
    localparam logic [D_WIDTH-1:0]    EOM_CHAR = 8'hFA;

    typedef enum logic [1:0] {
        CH_CAESAR  = 2'd0,
        CH_SCYTALE = 2'd1,
        CH_ZIGZAG  = 2'd2,
        CH_ILLEGAL = 2'd3
    } channel_e;

    typedef enum logic {
        StIdle,
        StMsg
    } in_state_e;

    // True for a selector code that names a real decryptor.
    function automatic logic is_legal_channel(input logic [1:0] ch);
        return ch != CH_ILLEGAL;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-low reset.
//   clk, rst_n       - clock, synchronous active-low reset
//   push_i, wdata_i  - write request and data (ignored when full)
//   pop_i, rdata_o   - read request (ignored when empty), head entry (show-ahead)
//   full_o, empty_o  - occupancy flags
//   count_o          - number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rd_ptr];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    // Storage is not reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/demux_dispatch.sv
// demux_dispatch: input-side dispatcher of the decryption datapath.
// Buffers a valid/ready character stream and routes each message to one of
// three decryptors; the channel is locked at the first character of a message
// and released by the end-of-message character (which is forwarded too).
//   clk, rst_n                 - clock, synchronous active-low reset
//   select                     - channel for the next message (3 = illegal)
//   data_i, valid_i, ready_o   - input character handshake
//   dataK_o, validK_o (K=0..2) - registered per-channel character and pulse
//   busyK_i (K=0..2)           - channel K cannot take a character this cycle
//   err_o                      - pulse per discarded illegal-message character
module demux_dispatch #(
    parameter int unsigned          D_WIDTH    = decrypt_pkg::D_WIDTH,
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter logic [D_WIDTH-1:0]   EOM_CHAR   = D_WIDTH'(decrypt_pkg::EOM_CHAR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         select,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [D_WIDTH-1:0] data0_o,
    output logic [D_WIDTH-1:0] data1_o,
    output logic [D_WIDTH-1:0] data2_o,
    output logic               valid0_o,
    output logic               valid1_o,
    output logic               valid2_o,
    input  logic               busy0_i,
    input  logic               busy1_i,
    input  logic               busy2_i,
    output logic               err_o
);

    import decrypt_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EW = D_WIDTH + 2;

    in_state_e          r_state;
    logic [1:0]         r_msg_sel;

    logic               w_accept;
    logic [1:0]         w_tag;
    logic [EW-1:0]      w_wdata;
    logic [EW-1:0]      w_head;
    logic [1:0]         w_head_tag;
    logic [D_WIDTH-1:0] w_head_data;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic               w_pop;

    // Depends on the stored count only, so a pop in this cycle never
    // re-opens the input until the following cycle.
    assign ready_o  = (w_count < CW'(FIFO_DEPTH));
    assign w_accept = valid_i && !w_full;

    // First character of a message takes the live selector; the rest reuse
    // the latched one so selector changes mid-message are ignored.
    assign w_tag   = (r_state == StIdle) ? select : r_msg_sel;
    assign w_wdata = {w_tag, data_i};

    assign w_head_tag  = w_head[D_WIDTH +: 2];
    assign w_head_data = w_head[D_WIDTH-1:0];

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_accept),
        .wdata_i (w_wdata),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Illegal-channel entries always drain; legal ones wait for their
    // channel, stalling everything behind them (no reordering).
    always_comb begin
        w_pop = 1'b0;
        if (!w_empty) begin
            if (!is_legal_channel(w_head_tag)) begin
                w_pop = 1'b1;
            end else begin
                unique case (w_head_tag)
                    CH_CAESAR:  w_pop = !busy0_i;
                    CH_SCYTALE: w_pop = !busy1_i;
                    CH_ZIGZAG:  w_pop = !busy2_i;
                    default:    w_pop = 1'b0;
                endcase
            end
        end
    end

    // Message-tracking FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_msg_sel <= CH_CAESAR;
        end else if (w_accept) begin
            unique case (r_state)
                StIdle: begin
                    r_msg_sel <= select;
                    // A lone EOM is a complete one-character message.
                    if (data_i != EOM_CHAR) begin
                        r_state <= StMsg;
                    end
                end
                StMsg: begin
                    if (data_i == EOM_CHAR) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Output registers: every output is zero except in the cycle after a pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data0_o  <= '0;
            data1_o  <= '0;
            data2_o  <= '0;
            valid0_o <= 1'b0;
            valid1_o <= 1'b0;
            valid2_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            data0_o  <= '0;
            data1_o  <= '0;
            data2_o  <= '0;
            valid0_o <= 1'b0;
            valid1_o <= 1'b0;
            valid2_o <= 1'b0;
            err_o    <= 1'b0;
            if (w_pop) begin
                unique case (w_head_tag)
                    CH_CAESAR: begin
                        data0_o  <= w_head_data;
                        valid0_o <= 1'b1;
                    end
                    CH_SCYTALE: begin
                        data1_o  <= w_head_data;
                        valid1_o <= 1'b1;
                    end
                    CH_ZIGZAG: begin
                        data2_o  <= w_head_data;
                        valid2_o <= 1'b1;
                    end
                    default: err_o <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_dispatch.sv
module tb_demux_dispatch;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  EOM   = 8'hFA;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    select;
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data0_o, data1_o, data2_o;
    logic          valid0_o, valid1_o, valid2_o;
    logic [2:0]    bsy;
    logic          err_o;

    always #5 clk = ~clk;

    demux_dispatch #(
        .D_WIDTH    (DW),
        .FIFO_DEPTH (DEPTH),
        .EOM_CHAR   (EOM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .select   (select),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .data1_o  (data1_o),
        .data2_o  (data2_o),
        .valid0_o (valid0_o),
        .valid1_o (valid1_o),
        .valid2_o (valid2_o),
        .busy0_i  (bsy[0]),
        .busy1_i  (bsy[1]),
        .busy2_i  (bsy[2]),
        .err_o    (err_o)
    );

    // Reference model: a queue of {channel, char} plus "inside a message" flag.
    typedef struct packed {
        logic [1:0] tag;
        logic [7:0] data;
    } ent_t;

    ent_t       m_q[$];
    bit         m_in_msg;
    logic [1:0] m_sel;
    bit         m_acc;
    int         busy_hold;

    // What the DUT delivered, for message-level checks.
    logic [7:0] log0[$], log1[$], log2[$];
    int         n_err_obs;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input logic [7:0] got[$], input int n,
                           input logic [63:0] exp);
        chk({tag, "_len"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk(tag, 32'(got[i]), 32'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        log2.delete();
        n_err_obs = 0;
    endtask

    // One clock cycle: check ready, advance the model on the current inputs,
    // take the edge, then check the registered outputs.
    task automatic tick();
        ent_t       head;
        int         pre;
        logic [3:0] b4;
        logic [3:0] e_v;
        logic [7:0] e_d [4];
        logic       e_err;

        chk("ready_o", 32'(ready_o), 32'(m_q.size() < DEPTH));
        b4    = {1'b0, bsy};
        e_v   = '0;
        e_d   = '{default: 8'h00};
        e_err = 1'b0;
        m_acc = 1'b0;
        pre   = m_q.size();
        if (!rst_n) begin
            m_q.delete();
            m_in_msg = 1'b0;
            m_sel    = 2'd0;
        end else begin
            if (pre > 0) begin
                head = m_q[0];
                if (head.tag == 2'd3) begin
                    e_err = 1'b1;
                    void'(m_q.pop_front());
                end else if (!b4[head.tag]) begin
                    e_v[head.tag] = 1'b1;
                    e_d[head.tag] = head.data;
                    void'(m_q.pop_front());
                end
            end
            if (valid_i && pre < DEPTH) begin
                m_acc = 1'b1;
                if (!m_in_msg) begin
                    m_sel    = select;
                    m_in_msg = (data_i != EOM);
                end else if (data_i == EOM) begin
                    m_in_msg = 1'b0;
                end
                m_q.push_back('{tag: m_sel, data: data_i});
            end
        end
        @(posedge clk);
        #1;
        chk("valid0_o", 32'(valid0_o), 32'(e_v[0]));
        chk("valid1_o", 32'(valid1_o), 32'(e_v[1]));
        chk("valid2_o", 32'(valid2_o), 32'(e_v[2]));
        chk("data0_o", 32'(data0_o), 32'(e_d[0]));
        chk("data1_o", 32'(data1_o), 32'(e_d[1]));
        chk("data2_o", 32'(data2_o), 32'(e_d[2]));
        chk("err_o", 32'(err_o), 32'(e_err));
        if (valid0_o) log0.push_back(data0_o);
        if (valid1_o) log1.push_back(data1_o);
        if (valid2_o) log2.push_back(data2_o);
        if (err_o) n_err_obs++;
        if (busy_hold > 0) begin
            busy_hold--;
            if (busy_hold == 0) bsy = 3'b000;
        end
    endtask

    // Hold one character on the input until the model says it was taken.
    task automatic send(input logic [7:0] d);
        int budget;
        valid_i = 1'b1;
        data_i  = d;
        budget  = 0;
        do begin
            tick();
            budget++;
        end while (!m_acc && budget < 40);
        if (!m_acc) begin
            vectors++;
            miscompares++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted data=%0h", d);
        end
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        busy_hold   = 0;
        m_in_msg    = 1'b0;
        m_sel       = 2'd0;
        rst_n       = 1'b0;
        select      = 2'd0;
        data_i      = '0;
        valid_i     = 1'b0;
        bsy         = 3'b000;
        clear_logs();

        // Reset state.
        @(posedge clk);
        #1;
        tick();
        rst_n = 1'b1;
        chk("reset_ready", 32'(ready_o), 32'd1);
        idle(1);

        // "AB",EOM to channel 1, back to back.
        clear_logs();
        select = 2'd1;
        send(8'h41);
        send(8'h42);
        send(EOM);
        idle(4);
        chk_log("msg1_ch1", log1, 3, 64'h41_42_FA);
        chk_log("msg1_ch0", log0, 0, 64'h0);
        chk_log("msg1_ch2", log2, 0, 64'h0);

        // Channel locked for the whole message despite a select change.
        clear_logs();
        select = 2'd0;
        send(8'h10);
        select = 2'd2;
        send(8'h11);
        send(8'h12);
        send(EOM);
        send(8'h43);
        send(EOM);
        idle(4);
        chk_log("lock_ch0", log0, 4, 64'h10_11_12_FA);
        chk_log("lock_ch2", log2, 2, 64'h43_FA);
        chk_log("lock_ch1", log1, 0, 64'h0);

        // Channel 2 busy for 6 cycles while streaming 8 characters.
        clear_logs();
        select    = 2'd2;
        bsy       = 3'b100;
        busy_hold = 6;
        for (int i = 0; i < 7; i++) send(8'h60 + 8'(i));
        send(EOM);
        idle(6);
        chk_log("busy_ch2", log2, 8, 64'h60_61_62_63_64_65_66_FA);

        // Illegal select: every character discarded with an error pulse.
        clear_logs();
        select = 2'd3;
        send(8'h58);
        send(8'h59);
        send(EOM);
        select = 2'd0;
        send(8'h5A);
        send(EOM);
        idle(4);
        chk("illegal_err_count", 32'(n_err_obs), 32'd3);
        chk_log("illegal_ch0", log0, 2, 64'h5A_FA);
        chk_log("illegal_ch1", log1, 0, 64'h0);
        chk_log("illegal_ch2", log2, 0, 64'h0);

        // Mid-message reset with 3 characters buffered.
        clear_logs();
        select = 2'd0;
        bsy    = 3'b001;
        send(8'h31);
        send(8'h32);
        send(8'h33);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bsy   = 3'b000;
        chk("midrst_ready", 32'(ready_o), 32'd1);
        select = 2'd1;
        send(8'h44);
        send(EOM);
        idle(4);
        chk_log("midrst_ch0", log0, 0, 64'h0);
        chk_log("midrst_ch1", log1, 2, 64'h44_FA);

        // Full FIFO: a pop in the full cycle does not re-open ready that cycle.
        clear_logs();
        select = 2'd1;
        bsy    = 3'b010;
        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i));
        valid_i = 1'b1;
        data_i  = 8'h54;
        chk("full_ready", 32'(ready_o), 32'd0);
        bsy = 3'b000;
        tick();
        chk("after_pop_ready", 32'(ready_o), 32'd1);
        send(8'h54);
        send(EOM);
        idle(6);
        chk_log("full_ch1", log1, 6, 64'h50_51_52_53_54_FA);

        // Randomized traffic, busy and occasional resets against the model.
        for (int n = 0; n < 400; n++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            valid_i = ($urandom_range(0, 9) < 7);
            data_i  = ($urandom_range(0, 4) == 0) ? EOM : 8'($urandom_range(0, 255));
            select  = 2'($urandom_range(0, 3));
            bsy     = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0)};
            tick();
        end
        rst_n = 1'b1;
        bsy   = 3'b000;
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_dispatch.md
# demux_dispatch

Input-side dispatcher for the decryption datapath. Accepts a ciphertext character stream with a valid/ready handshake, buffers it in a small FIFO, and routes each message to one of three decryptor channels. Channel selection is locked per message and released by the end-of-message character. Backpressure from each decryptor is honoured. It is the counterpart of the output-side result mux.

## Interface
- D_WIDTH, 8, character width.
- FIFO_DEPTH, 4, buffered characters (power of two, ≥2).
- EOM_CHAR, 8'hFA, end-of-message marker, forwarded to the target.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- select  in  2  channel for next message: 0/1/2 valid, 3 illegal.
- data_i  in  D_WIDTH  input character.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block can accept data_i this cycle.
- data0_o / data1_o / data2_o  out  D_WIDTH  per-channel character.
- valid0_o / valid1_o / valid2_o  out  1  one-cycle pulse per delivered character.
- busy0_i / busy1_i / busy2_i  in  1  channel cannot take a character this cycle.
- err_o  out  1  one-cycle pulse per discarded character of an illegal-select message.

## Operation
- Transfer occurs on an edge where valid_i && ready_o. ready_o = (count < FIFO_DEPTH), combinational from count only, never from same-cycle pop.
- Input FSM: IDLE, MSG.
  - IDLE: on transfer, latch select into msg_sel and go to MSG. If the char equals EOM_CHAR, it is a one-char message and the FSM stays IDLE.
  - MSG: on transfer, use msg_sel; select changes are ignored. A transfer of EOM_CHAR returns the FSM to IDLE.
- Each FIFO entry stores {tag[1:0], data}. The tag is select in IDLE, msg_sel in MSG.
- Pop at an edge when the FIFO is non-empty and either:
  - tag k ∈ {0,1,2} and busy_k_i = 0: registered outputs data_k_o ← data, valid_k_o ← 1.
  - tag 3: entry discarded, err_o ← 1, no valid asserted.
  - Head with busy tag: stalls, no reordering.
- Every cycle without a pop to channel k: data_k_o = 0, valid_k_o = 0. err_o is 0 unless a tag-3 pop occurs.
- At most one pop per cycle. Push and pop may coincide when not full; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

## Timing
- Reset (synchronous, rst_n=0 at edge):
  - count=0, pointers=0, FSM=IDLE, msg_sel=0.
  - All data_k_o=0, valid_k_o=0, err_o=0.
  - ready_o=1 from the first post-reset cycle.
  - Mid-message reset flushes the FIFO. No partial message survives.
- Latency: a char accepted at edge t, with an empty FIFO and a non-busy target, pops at edge t+1. valid_k_o is high in the cycle after edge t+1.
- Throughput: one char/cycle sustained when the target never asserts busy.
- busy_k_i is sampled at the pop edge. valid_k_o is asserted only when busy_k_i was 0 at that edge.
- Full: with count=FIFO_DEPTH, ready_o=0 for that whole cycle even if a pop occurs at its edge. ready_o rises the cycle after the pop.

## Structure
- Shared package decrypt_pkg: D_WIDTH, EOM_CHAR, channel encodings CH_CAESAR=2'd0, CH_SCYTALE=2'd1, CH_ZIGZAG=2'd2, CH_ILLEGAL=2'd3.
- Sub-module sync_fifo:
  - Parameterised width and depth.
  - Outputs: full, empty, count.
  - Used here with width D_WIDTH+2.
- Top: input FSM, pop/route logic, output registers.

## Test plan
- Reset then select=1, send "AB",FA on back-to-back cycles, busy all 0 → valid1_o pulses with 41,42,FA on 3 consecutive cycles starting 1 cycle after the first accept; channels 0/2 stay 0.
- select=0, send 3 chars; flip select to 2 after the first char → all 3 chars plus FA on channel 0. The next message "C",FA with select=2 → channel 2.
- busy2_i=1 held 6 cycles while streaming 8 chars on select=2 → ready_o drops after 4 accepted; no valid2_o during busy. After release, chars arrive in order, one/cycle, none lost or duplicated.
- select=3, send "XY",FA → err_o pulses 3 times; all valid_k_o stay 0. The following select=0 message delivers normally.
- Mid-message rst_n=0 for 1 cycle with 3 chars buffered → all outputs 0 next cycle, ready_o=1, FSM IDLE. The new message uses the freshly sampled select.
- Full FIFO with simultaneous valid_i and pop → no acceptance that cycle (ready_o=0). Count goes 4→3, ready_o=1 the next cycle.
